// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: deserialises 11-bit frames, folds E0/F0 prefixes into
// per-event flags and queues whole key events in a first-word-fall-through FIFO.
module ps2_kbd_rx #(
    parameter int FIFO_DEPTH     = 8,
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          rd_en,
    output logic                          ev_valid,
    output logic [7:0]                    ev_code,
    output logic                          ev_break,
    output logic                          ev_ext,
    output logic [CNT_W-1:0]              key_count,
    output logic                          overflow,
    output logic                          parity_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // state bit 0 = extended seen, bit 1 = break seen
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    logic [2:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic          sample;
    logic          data_bit;

    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [1:0]    state_q, state_d;
    logic          parity_err_q, parity_err_d;

    logic          push_req;
    logic [9:0]    push_data;
    logic [7:0]    frame_byte;
    logic          frame_ok;

    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic [CNT_W-1:0] key_count_q;
    logic          overflow_q;
    logic          full, pop, push_ok;

    // Synchronisers idle high so releasing reset never looks like a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q <= 3'b111;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[1:0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
        end
    end

    assign sample     = clk_sync_q[2] & ~clk_sync_q[1];
    assign data_bit   = dat_sync_q[1];
    assign frame_byte = shift_q[8:1];
    assign frame_ok   = ~shift_q[0] & data_bit & (^shift_q[9:1]);

    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        to_cnt_d     = to_cnt_q;
        state_d      = state_q;
        parity_err_d = 1'b0;
        push_req     = 1'b0;
        push_data    = {state_q[0], state_q[1], frame_byte};
        if (sample) begin
            to_cnt_d = '0;
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = 4'd0;
                if (!frame_ok) begin
                    parity_err_d = 1'b1;
                    state_d      = ST_IDLE;
                end else if (frame_byte == 8'hE0) begin
                    state_d = state_q | ST_EXT;
                end else if (frame_byte == 8'hF0) begin
                    state_d = state_q | ST_BRK;
                end else begin
                    push_req = 1'b1;
                    state_d  = ST_IDLE;
                end
            end else begin
                shift_d[bit_cnt_q] = data_bit;
                bit_cnt_d          = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            // A stalled partial frame is abandoned along with any pending prefix.
            if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                to_cnt_d  = '0;
                bit_cnt_d = 4'd0;
                state_d   = ST_IDLE;
            end else begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q    <= 4'd0;
            shift_q      <= 10'd0;
            to_cnt_q     <= '0;
            state_q      <= ST_IDLE;
            parity_err_q <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            to_cnt_q     <= to_cnt_d;
            state_q      <= state_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign full    = (level_q == LW'(FIFO_DEPTH));
    assign pop     = rd_en & ev_valid;
    assign push_ok = push_req & (~full | pop);

    always_comb begin
        level_d = level_q;
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            key_count_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_ok && !push_data[8]) begin
                key_count_q <= key_count_q + CNT_W'(1);
            end
            if (push_req && full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Head entry is gated so the event outputs read zero whenever the FIFO is empty.
    assign ev_valid   = (level_q != '0);
    assign ev_code    = ev_valid ? mem_q[rd_ptr_q][7:0] : 8'd0;
    assign ev_break   = ev_valid & mem_q[rd_ptr_q][8];
    assign ev_ext     = ev_valid & mem_q[rd_ptr_q][9];
    assign key_count  = key_count_q;
    assign overflow   = overflow_q;
    assign parity_err = parity_err_q;
    assign fifo_level = level_q;

endmodule
